verilog_meetup_template_project: RTL and testbench
==================================================

// Module: verilog_meetup_template_project
// PURPOSE
// - Tiny-Tapeout user tile: 8-bit programmable up/down counter with prescaler, parallel load,
//   seven-segment hex display of the low nibble, and the full count on the bidirectional bus.
// - Sits directly under the TT harness; all I/O is the standard TT pin set.
// PARAMETERS
// - PRESCALE_W   24   width of the free-running prescaler counter; must be >= 21
// PORTS
// - clk      in   1  the single clock
// - rst      in   1  reset: synchronous, active-high
// - ena      in   1  tile enable; low = freeze all state
// - ui_in    in   8  [0] cnt_en, [1] dir (1=up), [2] load, [3] rsvd, [6:4] psel, [7] uio_drive
// - uo_out   out  8  [6:0] segments a..g (active-high) of count[3:0]; [7] see CONFIGURATION
// - uio_in   in   8  parallel load value
// - uio_out  out  8  count[7:0]
// - uio_oe   out  8  all 1s when ui_in[7]=1, else all 0s (combinational)
// BEHAVIOUR
// - One clock `clk`; reset `rst` is synchronous and active-high.
// - On reset: count=0, prescaler=0, wrap flag=0. uo_out=8'h3F (digit 0, bit7=0); uio_out=0.
// - Prescaler: free-running, increments every cycle while ena=1. tick=1 when its low 3*psel
//   bits are all ones. psel=0 gives a tick every cycle; psel=7 gives one tick every 2^21 cycles.
// - Register update, in priority order, only while ena=1:
//   1) load=1: count<=uio_in. Ignores tick and cnt_en. No wrap pulse.
//   2) cnt_en & tick: count<=count+1 (dir=1) or count-1 (dir=0), modulo 256.
//   3) otherwise count holds.
// - Wrap flag: registered one-cycle pulse, set in the same edge as FF->00 (up) or 00->FF (down).
// - ena=0: count, prescaler and flag all hold. Outputs keep driving the held state.
// - Latency: count changes on the clock edge after the qualifying inputs. uo_out/uio_out are
//   combinational from registers (no extra cycle).
// - 7-seg table (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E
//   E=79 F=71.
// - Reset asserted mid-count overrides load/count in that same edge.
// - Prescaler phase is never cleared by load or by a psel change.
// CONFIGURATION
// - VERILOG_MEETUP_PWM_EN defined: a free 8-bit PWM counter runs while ena=1 and resets to 0.
//   uo_out[7] = (pwm_ctr < count). count=0 -> constant 0; count=255 -> high 255 of 256 cycles.
// - Macro undefined: uo_out[7] = wrap flag pulse. No PWM logic is present.
// STRUCTURE
// - Package verilog_meetup_pkg: SEG7 lookup constant (16x7), ui_in bit-index localparams,
//   PSEL step constant (3).
// - Sub-module seg7_decoder (4-bit in, 7-bit out, purely combinational).
// - Top holds prescaler, counter, flag and optional PWM.
// TESTING
// - Reset: hold rst 2 cycles -> uo_out=8'h3F, uio_out=0, uio_oe=0 (ui_in[7]=0).
// - Up count, psel=0, ui_in=8'h83: 5 cycles -> uio_out=5, uio_oe=FF, uo_out[6:0]=6D.
// - Down wrap: load 8'h00, then dir=0 with cnt_en -> count=FF next edge;
//   wrap pulse for exactly 1 cycle (macro off).
// - Load priority: load=1 with cnt_en=1, uio_in=8'hA7 -> count=A7, segments=07.
// - Prescale psel=1 from reset: count increments once per 8 cycles (24 cycles -> 3).
// - ena=0 for 10 cycles mid-count -> count unchanged. PWM_EN with count=64 -> 64 high in 256.

Source files
------------

// File: rtl/verilog_meetup_pkg.sv
// Shared constants for the meetup counter tile: pin map, prescale step, 7-seg table.
// Optional PWM on uo_out[7] is enabled by VERILOG_MEETUP_PWM_EN.
package verilog_meetup_pkg;

   localparam int UI_CNT_EN  = 0;
   localparam int UI_DIR     = 1;
   localparam int UI_LOAD    = 2;
   localparam int UI_RSVD    = 3;
   localparam int UI_PSEL_LO = 4;
   localparam int UI_PSEL_HI = 6;
   localparam int UI_DRIVE   = 7;

   localparam int PSEL_STEP = 3;

   // Index 0 is the last element of the concatenation (digit 0).
   localparam logic [15:0][6:0] SEG7 = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-high seven-segment pattern (g..a).
// Part of the VERILOG_MEETUP_PWM_EN-configurable tile; not affected by it.
module seg7_decoder
   import verilog_meetup_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG7[nib_i];

endmodule

// File: rtl/verilog_meetup_template_project.sv
// TT tile: prescaled up/down 8-bit counter with load and 7-seg display.
// Define VERILOG_MEETUP_PWM_EN to put a count-driven PWM on uo_out[7].
module verilog_meetup_template_project
   import verilog_meetup_pkg::*;
#(
   parameter int PRESCALE_W = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [PRESCALE_W-1:0] mask;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wrap_q, wrap_d;
   logic                  tick;
   logic [2:0]            psel;
   logic [6:0]            seg;
   logic                  bit7;
   logic                  unused_rsvd;

   assign psel        = ui_in[UI_PSEL_HI:UI_PSEL_LO];
   assign unused_rsvd = ui_in[UI_RSVD];

   // Tick when the low 3*psel prescaler bits are all ones.
   assign mask = ~({PRESCALE_W{1'b1}} << (PSEL_STEP * int'(psel)));
   assign tick = ((pre_q & mask) == mask);

   always_comb begin
      pre_d  = pre_q;
      cnt_d  = cnt_q;
      wrap_d = wrap_q;
      if (ena) begin
         pre_d  = pre_q + PRESCALE_W'(1);
         wrap_d = 1'b0;
         if (ui_in[UI_LOAD]) begin
            cnt_d = uio_in;
         end else if (ui_in[UI_CNT_EN] && tick) begin
            if (ui_in[UI_DIR]) begin
               cnt_d  = cnt_q + 8'd1;
               wrap_d = (cnt_q == 8'hFF);
            end else begin
               cnt_d  = cnt_q - 8'd1;
               wrap_d = (cnt_q == 8'h00);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         cnt_q  <= 8'h00;
         wrap_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

`ifdef VERILOG_MEETUP_PWM_EN
   logic [7:0] pwm_q, pwm_d;

   assign pwm_d = ena ? pwm_q + 8'd1 : pwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= 8'h00;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign bit7 = (pwm_q < cnt_q);
   logic unused_wrap;
   assign unused_wrap = wrap_q;
`else
   assign bit7 = wrap_q;
`endif

   seg7_decoder u_seg (
      .nib_i (cnt_q[3:0]),
      .seg_o (seg)
   );

   assign uo_out  = {bit7, seg};
   assign uio_out = cnt_q;
   assign uio_oe  = {8{ui_in[UI_DRIVE]}};

endmodule

// File: tb/tb_verilog_meetup_template_project.sv
// Directed vector bench for the meetup counter tile.
// Bit 7 of uo_out is only compared when VERILOG_MEETUP_PWM_EN is undefined.
module tb_verilog_meetup_template_project;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   verilog_meetup_template_project dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

`ifdef VERILOG_MEETUP_PWM_EN
   localparam logic [7:0] UO_MASK = 8'h7F;
`else
   localparam logic [7:0] UO_MASK = 8'hFF;
`endif

   typedef struct {
      logic       rst;
      logic       ena;
      logic [7:0] ui;
      logic [7:0] uin;
      int         n;
      logic [7:0] uo;
      logic [7:0] uio;
      logic [7:0] oe;
   } vec_t;

   vec_t v[$];

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      //        rst   ena   ui     uin    n   uo     uio    oe
      v.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 2,  8'h3F, 8'h00, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h83, 8'h00, 5,  8'h6D, 8'h05, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h87, 8'hA7, 1,  8'h07, 8'hA7, 8'hFF});
      v.push_back('{1'b0, 1'b0, 8'h83, 8'h00, 10, 8'h07, 8'hA7, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h83, 8'h00, 1,  8'h7F, 8'hA8, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h84, 8'hFF, 1,  8'h71, 8'hFF, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h83, 8'h00, 1,  8'hBF, 8'h00, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h83, 8'h00, 1,  8'h06, 8'h01, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h04, 8'h00, 1,  8'h3F, 8'h00, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h01, 8'h00, 1,  8'hF1, 8'hFF, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1,  8'h71, 8'hFF, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h01, 8'h00, 1,  8'h79, 8'hFE, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3,  8'h79, 8'hFE, 8'h00});
      v.push_back('{1'b1, 1'b1, 8'h85, 8'h55, 1,  8'h3F, 8'h00, 8'hFF});
      v.push_back('{1'b0, 1'b1, 8'h13, 8'h00, 24, 8'h4F, 8'h03, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h13, 8'h00, 7,  8'h4F, 8'h03, 8'h00});
      v.push_back('{1'b0, 1'b1, 8'h13, 8'h00, 1,  8'h66, 8'h04, 8'h00});

      foreach (v[i]) begin
         rst    = v[i].rst;
         ena    = v[i].ena;
         ui_in  = v[i].ui;
         uio_in = v[i].uin;
         step(v[i].n);
         chk($sformatf("v%0d uo_out", i), uo_out & UO_MASK, v[i].uo & UO_MASK);
         chk($sformatf("v%0d uio_out", i), uio_out, v[i].uio);
         chk($sformatf("v%0d uio_oe", i), uio_oe, v[i].oe);
      end

      // uio_oe follows ui_in[7] without a clock edge
      ui_in = 8'h80;
      #1;
      chk("oe comb hi", uio_oe, 8'hFF);
      ui_in = 8'h00;
      #1;
      chk("oe comb lo", uio_oe, 8'h00);

      // ena=0 freezes prescaler phase: 3 + 4 enabled edges, no tick yet
      rst = 1'b1;
      step(1);
      rst   = 1'b0;
      ui_in = 8'h13;
      step(3);
      ena = 1'b0;
      step(20);
      ena = 1'b1;
      step(4);
      chk("pre frozen cnt0", uio_out, 8'h00);
      step(1);
      chk("pre frozen cnt1", uio_out, 8'h01);

      // psel change does not clear phase: pre now 8, switch to psel=0
      ui_in = 8'h03;
      step(2);
      chk("psel switch", uio_out, 8'h03);

`ifdef VERILOG_MEETUP_PWM_EN
      begin
         int hi;
         ui_in  = 8'h04;
         uio_in = 8'h40;
         step(1);
         ui_in = 8'h00;
         hi    = 0;
         for (int k = 0; k < 256; k++) begin
            if (uo_out[7]) hi++;
            step(1);
         end
         chk("pwm 64", 8'(hi), 8'd64);
         ui_in  = 8'h04;
         uio_in = 8'h00;
         step(1);
         ui_in = 8'h00;
         hi    = 0;
         for (int k = 0; k < 256; k++) begin
            if (uo_out[7]) hi++;
            step(1);
         end
         chk("pwm 0", 8'(hi), 8'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
